uart_digit_tx: RTL and testbench



---
 rtl/uart_digit_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_digit_tx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_digit_tx.sv
// Captures a multi-digit number on request and sends it over 8N1 UART as ASCII, most-significant digit first.
// Optional CR/LF trailer after each message when UART_DIGIT_TX_CRLF_EN is defined.
module uart_digit_tx #(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE                   = 115_200,
  parameter int unsigned NUMBER_OF_DIGITS            = 4,
  parameter int unsigned NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  input  logic                                                 send,
  output logic                                                 tx,
  output logic                                                 busy,
  output logic                                                 done
);

  localparam int unsigned CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int unsigned BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned NUM_W        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
`ifdef UART_DIGIT_TX_CRLF_EN
  localparam int unsigned TRAILER_CHARS = 2;
`else
  localparam int unsigned TRAILER_CHARS = 0;
`endif
  localparam int unsigned NUM_CHARS = NUMBER_OF_DIGITS + TRAILER_CHARS;
  localparam int unsigned IDX_W     = $clog2(NUM_CHARS + 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_digit_tx: CLKS_PER_BIT must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e                  state_q, state_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic [2:0]              bit_q, bit_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_W-1:0]        shadow_q, shadow_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    bit_end_c;
  logic                    last_char_c;
  logic [7:0]              char_c;

  function automatic logic [7:0] digit_to_ascii(input logic [NUMBER_OF_BITS_PER_DIGIT-1:0] d);
    int unsigned v;
    v = 32'(d);
    if (v < 10)      return 8'(32'h30 + v);
    else if (v < 16) return 8'(32'h41 + v - 10);
    else             return 8'h3F;
  endfunction

  // Character slot 0 is the most significant digit; trailer slots follow the digits.
  function automatic logic [7:0] char_at(input logic [IDX_W-1:0] idx, input logic [NUM_W-1:0] val);
    logic [7:0] c;
    c = 8'h3F;
    for (int unsigned i = 0; i < NUMBER_OF_DIGITS; i++) begin
      if (32'(idx) == NUMBER_OF_DIGITS - 1 - i)
        c = digit_to_ascii(val[i*NUMBER_OF_BITS_PER_DIGIT +: NUMBER_OF_BITS_PER_DIGIT]);
    end
`ifdef UART_DIGIT_TX_CRLF_EN
    if (32'(idx) == NUMBER_OF_DIGITS)     c = 8'h0D;
    if (32'(idx) == NUMBER_OF_DIGITS + 1) c = 8'h0A;
`endif
    return c;
  endfunction

  assign bit_end_c   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_char_c = (idx_q == IDX_W'(NUM_CHARS - 1));
  assign char_c      = char_at(idx_d, shadow_d);

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state and datapath sequencing.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        idx_d  = '0;
        if (send) begin
          shadow_d = number;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          bit_d  = '0;
          if (last_char_c) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the upcoming state so the registered line changes on the transition edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && bit_end_c && last_char_c;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = char_c[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_digit_tx.sv
// Directed bench for uart_digit_tx: per-cycle waveform model of each message plus reset and handshake corner cases.
module tb_uart_digit_tx;

  localparam int C = 10;
`ifdef UART_DIGIT_TX_CRLF_EN
  localparam int NCH = 6;
`else
  localparam int NCH = 4;
`endif
  localparam int TOT = NCH * 10 * C;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] number;
  logic        send;
  logic        tx, busy, done;

  int checks   = 0;
  int failures = 0;

  uart_digit_tx #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ(1_000_000),
    .BAUD_RATE                  (100_000),
    .NUMBER_OF_DIGITS           (4),
    .NUMBER_OF_BITS_PER_DIGIT   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .number(number),
    .send  (send),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] num;
    logic [47:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Character 0 in the low byte; CR/LF always in the top two bytes.
  function automatic logic [47:0] mk(input logic [7:0] b0, b1, b2, b3);
    return {8'h0A, 8'h0D, b3, b2, b1, b0};
  endfunction

  task automatic run_msg(input string name, input logic [15:0] num, input logic [47:0] exp,
                         input int poke_t, input logic [15:0] poke_num, output logic [9:0] f0);
    int wave_bad, busy_bad, done_bad;
    logic [7:0] rx;
    wave_bad = 0; busy_bad = 0; done_bad = 0; rx = '0; f0 = '0;
    @(negedge clk); number = num; send = 1'b1;
    @(negedge clk); send = 1'b0;
    for (int t = 0; t < TOT + 40; t++) begin
      int c, b, o;
      logic e;
      c = t / (10 * C); b = (t % (10 * C)) / C; o = t % C;
      if (t >= TOT)    e = 1'b1;
      else if (b == 0) e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = exp[8*c + b - 1];
      if (tx !== e) wave_bad++;
      if (busy !== 1'(t < TOT)) busy_bad++;
      if (done !== 1'(t == TOT)) done_bad++;
      if (t < TOT && o == C / 2) begin
        if (c == 0) f0[b] = tx;
        if (b >= 1 && b <= 8) rx[b-1] = tx;
        if (b == 9) check($sformatf("%s_char%0d", name, c), 64'(rx), 64'(exp[8*c +: 8]));
      end
      if (t == poke_t) begin number = poke_num; send = 1'b1; end
      else if (t == poke_t + 1) send = 1'b0;
      @(negedge clk);
    end
    check({name, "_tx_wave_errs"}, 64'(wave_bad), 64'(0));
    check({name, "_busy_errs"}, 64'(busy_bad), 64'(0));
    check({name, "_done_errs"}, 64'(done_bad), 64'(0));
  endtask

  initial begin
    vec_t        vecs[5];
    logic [9:0]  f0;
    int          bad, t_done;
    bit          seen;

    vecs[0] = '{"msg1234", 16'h1234, mk(8'h31, 8'h32, 8'h33, 8'h34)};
    vecs[1] = '{"msgA0F9", 16'hA0F9, mk(8'h41, 8'h30, 8'h46, 8'h39)};
    vecs[2] = '{"msg0000", 16'h0000, mk(8'h30, 8'h30, 8'h30, 8'h30)};
    vecs[3] = '{"msgFFFF", 16'hFFFF, mk(8'h46, 8'h46, 8'h46, 8'h46)};
    vecs[4] = '{"msg9A5B", 16'h9A5B, mk(8'h39, 8'h41, 8'h35, 8'h42)};

    rst = 1'b1; send = 1'b0; number = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check("idle_stable_errs", 64'(bad), 64'(0));

    for (int v = 0; v < 5; v++) begin
      run_msg(vecs[v].name, vecs[v].num, vecs[v].exp, -10, 16'h0, f0);
      if (v == 1) check("frame_0x41_bits", 64'(f0), 64'(10'b1010000010));
    end

    // Send while busy is ignored and the captured value is isolated from later changes.
    run_msg("ignore", 16'h1111, mk(8'h31, 8'h31, 8'h31, 8'h31), 150, 16'h9999, f0);

    // rst together with send: nothing captured.
    @(negedge clk); rst = 1'b1; send = 1'b1; number = 16'h1234;
    @(negedge clk); rst = 1'b0; send = 1'b0;
    @(negedge clk);
    check("rst_send_busy", 64'(busy), 64'(0));
    check("rst_send_tx", 64'(tx), 64'(1));

    // Reset during DATA of the second character.
    @(negedge clk); number = 16'h1234; send = 1'b1;
    @(negedge clk); send = 1'b0;
    repeat (130) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", 64'(tx), 64'(1));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    bad = 0;
    for (int i = 0; i < TOT + 20; i++) begin
      if (done !== 1'b0 || tx !== 1'b1) bad++;
      @(negedge clk);
    end
    check("midrst_quiet_errs", 64'(bad), 64'(0));
    run_msg("after_rst", 16'h1234, mk(8'h31, 8'h32, 8'h33, 8'h34), -10, 16'h0, f0);

    // Back-to-back with send held high.
    @(negedge clk); number = 16'h5678; send = 1'b1;
    @(negedge clk);
    seen = 1'b0; t_done = -1;
    for (int t = 0; t < 2 * TOT && !seen; t++) begin
      if (done === 1'b1) begin seen = 1'b1; t_done = t; end
      else @(negedge clk);
    end
    check("b2b_done_seen", 64'(seen), 64'(1));
    check("b2b_done_cycle", 64'(t_done), 64'(TOT));
    check("b2b_tx_at_done", 64'(tx), 64'(1));
    @(negedge clk);
    check("b2b_start_tx", 64'(tx), 64'(0));
    check("b2b_start_busy", 64'(busy), 64'(1));
    check("b2b_done_width", 64'(done), 64'(0));
    send = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
